// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package run_det_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL    = 2'd0,
        MODE_PULSE    = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_TOTAL    = 2'd3
    } mode_e;

    // Largest value a counter of the given width can hold.
    function automatic logic [31:0] cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Sample/config/result bundle between the serial front end and the run-length detector.
// Latency: none (wiring only).
// Backpressure: none; the enable qualifies each sample, the detector never stalls.
interface run_length_detector_if #(
    parameter int CNT_W = 5
);
    logic             en;
    logic             a;
    logic [1:0]       mode;
    logic [CNT_W-1:0] thresh;
    logic             thresh_ld;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    modport master (
        output en, a, mode, thresh, thresh_ld,
        input  s, cnt, sat
    );

    modport slave (
        input  en, a, mode, thresh, thresh_ld,
        output s, cnt, sat
    );
endinterface

// File: rtl/run_det_maj3.sv
// Three-sample majority glitch filter on the serial input, advanced only on enabled cycles.
// Latency: a step on din appears on dout after 2 enabled cycles.
// Backpressure: none; history holds while en=0.
module run_det_maj3 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [2:0] hist;

    // Shift in one sample per enabled cycle; reset clears history to all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 3'b000;
        end else if (en) begin
            hist <= {hist[1:0], din};
        end
    end

    assign dout = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/run_length_detector.sv
// Counts runs/totals of 1s on a serial input and flags them against a runtime threshold.
// Latency: s/cnt/sat are registered, one enabled cycle after the causing sample
//          (plus 2 enabled cycles when built with RUN_DET_GLITCH_FILTER_EN).
// Backpressure: none; en=0 freezes the state, thresh_ld is accepted regardless of en.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int THRESH_RST = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    run_length_detector_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] THR_RST = CNT_W'(THRESH_RST);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] thr_q;
    logic             s_q;
    logic             sat_q;
    logic             hit_q;
    mode_e            mode_q;

    logic             ai;
    mode_e            mode_cur;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic             hit;
    logic             s_nxt;

`ifdef RUN_DET_GLITCH_FILTER_EN
    run_det_maj3 u_maj3 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .din  (bus.a),
        .dout (ai)
    );
`else
    assign ai = bus.a;
`endif

    // Next counter value, hit and detect output for the current enabled sample.
    always_comb begin
        mode_cur = mode_e'(bus.mode);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_nxt  = cnt_q;
        wrap     = 1'b0;
        hit      = 1'b0;
        s_nxt    = 1'b0;

        if (mode_cur != mode_q) begin
            // A mode switch discards the run in progress; the new mode starts clean.
            cnt_nxt = '0;
        end else begin
            unique case (mode_q)
                MODE_LEVEL, MODE_PULSE: begin
                    cnt_nxt = ai ? cnt_inc : '0;
                end
                MODE_PERIODIC: begin
                    // Compare one bit wider so cnt_q at max never aliases to a zero threshold.
                    if (ai) begin
                        wrap    = (thr_q != '0) &&
                                  (({1'b0, cnt_q} + 1'b1) == {1'b0, thr_q});
                        cnt_nxt = wrap ? '0 : cnt_inc;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                MODE_TOTAL: begin
                    cnt_nxt = ai ? cnt_inc : cnt_q;
                end
                default: begin
                    cnt_nxt = '0;
                end
            endcase

            // A zero threshold disables detection in every mode.
            if (mode_q == MODE_PERIODIC) begin
                hit = wrap;
            end else begin
                hit = (thr_q != '0) && (cnt_nxt >= thr_q);
            end

            unique case (mode_q)
                MODE_LEVEL:    s_nxt = hit;
                MODE_PERIODIC: s_nxt = wrap;
                default:       s_nxt = hit & ~hit_q;
            endcase
        end
    end

    // State update: threshold loads any cycle, everything else only on enabled samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            thr_q  <= THR_RST;
            s_q    <= 1'b0;
            sat_q  <= 1'b0;
            hit_q  <= 1'b0;
            mode_q <= MODE_LEVEL;
        end else begin
            if (bus.thresh_ld) begin
                thr_q <= bus.thresh;
            end
            if (bus.en) begin
                mode_q <= mode_cur;
                cnt_q  <= cnt_nxt;
                hit_q  <= hit;
                s_q    <= s_nxt;
                sat_q  <= (cnt_nxt == CNT_MAX);
            end else if (mode_q != MODE_LEVEL) begin
                // Pulse-style outputs must not stretch across a stalled cycle.
                s_q <= 1'b0;
            end
        end
    end

    assign bus.s   = s_q;
    assign bus.cnt = cnt_q;
    assign bus.sat = sat_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector (CNT_W=5); filter build runs the filter section.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: en is driven directly by the bench.
module tb_run_length_detector;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    int   tot_a[8];
    int   tot_c[8];

    run_length_detector_if #(.CNT_W(5)) bus ();

    run_length_detector #(
        .CNT_W      (5),
        .THRESH_RST (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_mode(input logic [1:0] m, input logic [4:0] t);
        bus.mode      = m;
        bus.thresh    = t;
        bus.thresh_ld = 1'b1;
        bus.a         = 1'b0;
        step();
        bus.thresh_ld = 1'b0;
        chk("mode_chg_cnt", 32'(bus.cnt), 0);
        chk("mode_chg_s", 32'(bus.s), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tot_a = '{1, 0, 1, 0, 1, 1, 0, 1};
        tot_c = '{1, 1, 2, 2, 3, 4, 4, 5};

        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.a         = 1'b0;
        bus.mode      = 2'd0;
        bus.thresh    = 5'd0;
        bus.thresh_ld = 1'b0;
        step();
        step();
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_sat", 32'(bus.sat), 0);
        rst = 1'b0;

`ifdef RUN_DET_GLITCH_FILTER_EN
        // Filter history starts at zero; threshold 3 loaded while disabled.
        bus.thresh    = 5'd3;
        bus.thresh_ld = 1'b1;
        step();
        bus.thresh_ld = 1'b0;
        bus.en        = 1'b1;
        begin
            int fa[8] = '{1, 1, 0, 1, 1, 0, 0, 0};
            int fc[8] = '{0, 0, 1, 2, 3, 4, 5, 0};
            for (int i = 0; i < 8; i++) begin
                bus.a = fa[i][0];
                step();
                chk($sformatf("filt_cnt[%0d]", i), 32'(bus.cnt), 32'(fc[i]));
                chk($sformatf("filt_s[%0d]", i), 32'(bus.s), 32'(fc[i] >= 3));
            end
            for (int i = 0; i < 6; i++) begin
                bus.a = (i == 0);
                step();
                chk($sformatf("filt_iso_cnt[%0d]", i), 32'(bus.cnt), 0);
            end
        end
`else
        // LEVEL, default threshold 20.
        bus.en = 1'b1;
        bus.a  = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            chk($sformatf("lvl_cnt[%0d]", i), 32'(bus.cnt), 32'(i));
            chk($sformatf("lvl_s[%0d]", i), 32'(bus.s), 32'(i >= 20));
        end
        bus.a = 1'b0;
        step();
        chk("lvl_drop_cnt", 32'(bus.cnt), 0);
        chk("lvl_drop_s", 32'(bus.s), 0);

        // PULSE, threshold 4.
        load_mode(2'd1, 5'd4);
        bus.a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("pls_cnt[%0d]", i), 32'(bus.cnt), 32'(i));
            chk($sformatf("pls_s[%0d]", i), 32'(bus.s), 32'(i == 4));
        end
        bus.a = 1'b0;
        step();
        chk("pls_gap_s", 32'(bus.s), 0);
        chk("pls_gap_cnt", 32'(bus.cnt), 0);
        bus.a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("pls2_s[%0d]", i), 32'(bus.s), 32'(i == 4));
        end

        // PERIODIC, threshold 3.
        load_mode(2'd2, 5'd3);
        bus.a = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("per_cnt[%0d]", i), 32'(bus.cnt), 32'(i % 3));
            chk($sformatf("per_s[%0d]", i), 32'(bus.s), 32'((i % 3) == 0));
        end

        // TOTAL, threshold 5.
        load_mode(2'd3, 5'd5);
        for (int i = 0; i < 8; i++) begin
            bus.a = tot_a[i][0];
            step();
            chk($sformatf("tot_cnt[%0d]", i), 32'(bus.cnt), 32'(tot_c[i]));
            chk($sformatf("tot_s[%0d]", i), 32'(bus.s), 32'(i == 7));
        end
        bus.a = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk($sformatf("tot_sat_s[%0d]", i), 32'(bus.s), 0);
            chk($sformatf("tot_sat_flag[%0d]", i), 32'(bus.sat), 32'((5 + i) >= 31));
        end
        chk("tot_sat_cnt", 32'(bus.cnt), 31);

        // Zero threshold: LEVEL then PERIODIC never assert s, counter still runs.
        load_mode(2'd0, 5'd0);
        bus.a = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("thr0_lvl_cnt[%0d]", i), 32'(bus.cnt), 32'(i));
            chk($sformatf("thr0_lvl_s[%0d]", i), 32'(bus.s), 0);
        end
        load_mode(2'd2, 5'd0);
        bus.a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("thr0_per_cnt[%0d]", i), 32'(bus.cnt), 32'(i));
            chk($sformatf("thr0_per_s[%0d]", i), 32'(bus.s), 0);
        end

        // Reset mid LEVEL run at cnt=10.
        load_mode(2'd0, 5'd20);
        bus.a = 1'b1;
        for (int i = 1; i <= 10; i++) step();
        chk("mid_run_cnt", 32'(bus.cnt), 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(bus.cnt), 0);
        chk("mid_rst_s", 32'(bus.s), 0);

        // Mode switch LEVEL->PULSE mid run.
        for (int i = 1; i <= 3; i++) step();
        chk("sw_pre_cnt", 32'(bus.cnt), 3);
        bus.mode = 2'd1;
        step();
        chk("sw_cnt", 32'(bus.cnt), 0);
        chk("sw_s", 32'(bus.s), 0);
        step();
        chk("sw_post_cnt", 32'(bus.cnt), 1);
        step();
        step();
        chk("en_pre_cnt", 32'(bus.cnt), 3);

        // Stall for 5 cycles with a=0; threshold load still taken.
        bus.en = 1'b0;
        bus.a  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.thresh_ld = (i == 2);
            bus.thresh    = 5'd4;
            step();
            chk($sformatf("en0_cnt[%0d]", i), 32'(bus.cnt), 3);
        end
        bus.thresh_ld = 1'b0;
        bus.en        = 1'b1;
        bus.a         = 1'b1;
        step();
        chk("en1_cnt", 32'(bus.cnt), 4);
        chk("en1_s_newthr", 32'(bus.s), 1);

        // Threshold load while enabled: old value applies to this sample.
        load_mode(2'd0, 5'd20);
        bus.a = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        bus.thresh    = 5'd5;
        bus.thresh_ld = 1'b1;
        step();
        bus.thresh_ld = 1'b0;
        chk("ld_old_cnt", 32'(bus.cnt), 5);
        chk("ld_old_s", 32'(bus.s), 0);
        step();
        chk("ld_new_s", 32'(bus.s), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
